// File: rtl/alpha_mixer_pkg.sv
// alpha_mixer_pkg: shared types and constants for the alpha mixer.
// Holds the per-beat operation encoding and the fixed pipeline depth.
package alpha_mixer_pkg;

    // Per-beat operation selected on the mode input
    typedef enum logic [1:0] {
        BLEND   = 2'd0,
        FG_ONLY = 2'd1,
        BG_ONLY = 2'd2,
        ADD_SAT = 2'd3
    } mode_t;

    // Register stages between input transfer and out_valid
    localparam int unsigned PIPE_LATENCY = 32'd3;

endpackage

// File: rtl/alpha_mixer_lane.sv
// alpha_mixer_lane: one colour channel's multiply (S2) and
// sum/shift/saturate (S3) stages. Stage advance is decided by the parent.
// Optional feature macro: ALPHA_MIXER_ADD_SAT_EN enables the saturating
// additive mode; without it mode ADD_SAT falls back to BLEND.
module alpha_mixer_lane
    import alpha_mixer_pkg::*;
#(
    parameter int CW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s2_en,
    input  logic          s3_en,
    input  mode_t         mode,
    input  logic [CW-1:0] fg,
    input  logic [CW-1:0] bg,
    input  logic [AW:0]   a_exp,
    output logic [CW-1:0] res
);

    // Product width: CW-bit colour times (AW+1)-bit expanded alpha
    localparam int PW = CW + AW + 1;
    localparam logic [AW:0]   A_ONE   = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] SAT_MAX = {CW{1'b1}};

    logic [AW:0]   a_inv_s;
    logic [PW-1:0] p_fg_s;
    logic [PW-1:0] p_bg_s;
    logic [PW-1:0] p_fg_r;
    logic [PW-1:0] p_bg_r;
    logic [CW-1:0] fg_r;
    logic [CW-1:0] bg_r;
    mode_t         mode_r;
    logic [PW-1:0] sum_s;
    logic [CW:0]   blend_s;
    logic [CW-1:0] blend_sat_s;
`ifdef ALPHA_MIXER_ADD_SAT_EN
    logic [CW:0]   add_s;
    logic [CW-1:0] add_sat_s;
`endif
    logic [CW-1:0] res_s;
    logic [CW-1:0] res_r;

    // S2 operands: foreground weight a' and background weight 2^AW - a'
    always_comb begin
        a_inv_s = A_ONE - a_exp;
        p_fg_s  = PW'(fg) * PW'(a_exp);
        p_bg_s  = PW'(bg) * PW'(a_inv_s);
    end

    // S2 register: weighted products plus raw colours for the pass-through modes
    always_ff @(posedge clk) begin
        if (reset) begin
            p_fg_r <= '0;
            p_bg_r <= '0;
            fg_r   <= '0;
            bg_r   <= '0;
            mode_r <= BLEND;
        end else if (s2_en) begin
            p_fg_r <= p_fg_s;
            p_bg_r <= p_bg_s;
            fg_r   <= fg;
            bg_r   <= bg;
            mode_r <= mode;
        end
    end

    // S3 arithmetic: weights sum to 2^AW so the shifted blend cannot exceed
    // full scale; the clamp only guards the unused top bit.
    always_comb begin
        sum_s       = p_fg_r + p_bg_r;
        blend_s     = sum_s[PW-1:AW];
        blend_sat_s = blend_s[CW] ? SAT_MAX : blend_s[CW-1:0];
`ifdef ALPHA_MIXER_ADD_SAT_EN
        add_s       = {1'b0, bg_r} + p_fg_r[PW-1:AW];
        add_sat_s   = add_s[CW] ? SAT_MAX : add_s[CW-1:0];
`endif
        case (mode_r)
            FG_ONLY: res_s = fg_r;
            BG_ONLY: res_s = bg_r;
`ifdef ALPHA_MIXER_ADD_SAT_EN
            ADD_SAT: res_s = add_sat_s;
`endif
            BLEND:   res_s = blend_sat_s;
            default: res_s = blend_sat_s;
        endcase
    end

    // S3 register: result held while the output stage is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            res_r <= '0;
        end else if (s3_en) begin
            res_r <= res_s;
        end
    end

    assign res = res_r;

endmodule

// File: rtl/alpha_mixer.sv
// alpha_mixer: three-stage valid/ready pixel mixer (BLEND, FG_ONLY,
// BG_ONLY, ADD_SAT). S1 captures the beat and expands alpha, S2/S3 run in
// per-channel lanes; all handshake and valid tracking lives here.
// Optional feature macro: ALPHA_MIXER_ADD_SAT_EN (saturating additive mode).
module alpha_mixer
    import alpha_mixer_pkg::*;
#(
    parameter int CW  = 8,
    parameter int AW  = 4,
    parameter int CH  = 3,
    parameter int SBW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*CW-1:0] fg_pix,
    input  logic [CH*CW-1:0] bg_pix,
    input  logic [AW-1:0]    alpha,
    input  logic [1:0]       mode,
    input  logic [SBW-1:0]   sb_in,
    output logic [SBW-1:0]   sb_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*CW-1:0] out_pix
);

    localparam int XW = CH * CW;

    logic           s1_valid_r;
    logic           s2_valid_r;
    logic           s3_valid_r;
    logic           s1_en_s;
    logic           s2_en_s;
    logic           s3_en_s;
    logic           lane_s2_en_s;
    logic           lane_s3_en_s;
    logic [XW-1:0]  fg_r;
    logic [XW-1:0]  bg_r;
    logic [AW:0]    a_exp_s;
    logic [AW:0]    a_exp_r;
    mode_t          mode_r;
    logic [SBW-1:0] sb1_r;
    logic [SBW-1:0] sb2_r;
    logic [SBW-1:0] sb3_r;

    // Stage enables: a stage loads when empty or when its contents move on
    always_comb begin
        s3_en_s      = !s3_valid_r || out_ready;
        s2_en_s      = !s2_valid_r || s3_en_s;
        s1_en_s      = !s1_valid_r || s2_en_s;
        lane_s2_en_s = s2_en_s && s1_valid_r;
        lane_s3_en_s = s3_en_s && s2_valid_r;
        in_ready     = s1_en_s && !reset;
    end

    // Alpha expansion so that all-ones alpha maps to exactly 2^AW
    always_comb begin
        a_exp_s = {1'b0, alpha} + {{AW{1'b0}}, alpha[AW-1]};
    end

    // S1: capture the beat with its mode, expanded alpha and sideband
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            fg_r       <= '0;
            bg_r       <= '0;
            a_exp_r    <= '0;
            mode_r     <= BLEND;
            sb1_r      <= '0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                fg_r    <= fg_pix;
                bg_r    <= bg_pix;
                a_exp_r <= a_exp_s;
                mode_r  <= mode_t'(mode);
                sb1_r   <= sb_in;
            end
        end
    end

    // S2 valid flag and sideband, moving in step with the lane products
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            sb2_r      <= '0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sb2_r <= sb1_r;
            end
        end
    end

    // S3 valid flag and sideband, frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid_r <= 1'b0;
            sb3_r      <= '0;
        end else if (s3_en_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                sb3_r <= sb2_r;
            end
        end
    end

    assign out_valid = s3_valid_r;
    assign sb_out    = sb3_r;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        alpha_mixer_lane #(
            .CW(CW),
            .AW(AW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .s2_en (lane_s2_en_s),
            .s3_en (lane_s3_en_s),
            .mode  (mode_r),
            .fg    (fg_r[g*CW +: CW]),
            .bg    (bg_r[g*CW +: CW]),
            .a_exp (a_exp_r),
            .res   (out_pix[g*CW +: CW])
        );
    end

endmodule

// File: doc/alpha_mixer.md
ALPHA_MIXER -- requirements
Module: alpha_mixer

Interface
REQ-001 SHALL have parameter CW, default 8, colour component width in bits (4..12).
REQ-002 SHALL have parameter AW, default 4, alpha width in bits (1..8).
REQ-003 SHALL have parameter CH, default 3, number of colour channels (1..4).
REQ-004 SHALL have parameter SBW, default 3, sideband width (e.g. hs/vs/de), carried unmodified.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid; in_ready  out  1  block accepts beat this cycle.
REQ-008 fg_pix  in  CH*CW  foreground pixel, channel 0 in LSBs; bg_pix  in  CH*CW  background pixel, same packing.
REQ-009 alpha  in  AW  foreground opacity, 0 = transparent, all-ones = opaque.
REQ-010 mode  in  2  per-beat op: 0 BLEND, 1 FG_ONLY, 2 BG_ONLY, 3 ADD_SAT.
REQ-011 sb_in  in  SBW  sideband; sb_out  out  SBW  sideband aligned with out_pix.
REQ-012 out_valid  out  1; out_ready  in  1; out_pix  out  CH*CW  result pixel.

Function
REQ-013 Beat transfer SHALL occur on a rising edge where valid and ready are both high, at input and at output.
REQ-014 Datapath SHALL be 3 register stages (S1 alpha expand/capture, S2 multiply, S3 sum/shift/saturate); latency 3 cycles from input transfer to out_valid with out_ready held high.
REQ-015 Each stage SHALL load when its register is empty or its contents transfer downstream the same cycle; in_ready = !S1_full || S1_advances; full throughput of one beat per cycle with out_ready high.
REQ-016 out_pix, sb_out and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 BLEND: a' = alpha + alpha[AW-1] (AW+1 bits); per channel out = (fg*a' + bg*(2^AW - a')) >> AW, truncating; alpha=0 yields bg exactly, alpha all-ones yields fg exactly.
REQ-018 Intermediate sum SHALL be CW+AW+1 bits; result SHALL never exceed 2^CW-1 in BLEND.
REQ-019 FG_ONLY outputs fg, BG_ONLY outputs bg, both ignoring alpha, with identical 3-cycle latency.
REQ-020 ADD_SAT: out = min(bg + ((fg*a') >> AW), 2^CW-1) per channel.
REQ-021 mode, alpha and sb_in SHALL be captured with the beat; changing them mid-stream affects only subsequent beats.
REQ-022 No beat SHALL be dropped, duplicated or reordered under any out_ready pattern.
REQ-023 Simultaneous input accept and output drain with pipeline full SHALL sustain without bubble.

Reset
REQ-024 While reset=1: all stage-valid flags clear, out_valid=0, out_pix=0, sb_out=0, in_ready=0.
REQ-025 First cycle after reset deasserts: in_ready=1; beats in flight at reset assertion are discarded.

Configuration
REQ-026 Macro ALPHA_MIXER_ADD_SAT_EN: defined -> mode 3 behaves per REQ-020; undefined -> saturating adder absent and mode 3 behaves as BLEND.

Structure
REQ-027 Package alpha_mixer_pkg SHALL hold the mode enum typedef (BLEND, FG_ONLY, BG_ONLY, ADD_SAT) and the pipeline latency constant (3).
REQ-028 Sub-module alpha_mixer_lane SHALL implement one channel's S2/S3 arithmetic, instantiated CH times; handshake/valid logic stays in alpha_mixer.

Verification (CW=8, AW=4, CH=3)
REQ-029 fg=0xFF, bg=0x00, alpha=15, BLEND -> out 0xFF all channels, 3 cycles later; alpha=0 -> 0x00; alpha=8 -> 0x8F (255*9>>4).
REQ-030 fg=0x50, bg=0xC0, alpha=15, ADD_SAT -> 0xFF (saturated); with macro undefined -> 0x50.
REQ-031 out_ready=0 for 6 cycles, in_valid=1 continuously -> exactly 3 beats accepted, in_ready low thereafter; on release beats emerge in order, no loss or duplicate.
REQ-032 Random valid/ready toggling, 1000 beats with mixed modes/sideband -> output stream equals reference model stream, sb_out aligned.
REQ-033 reset asserted for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted afterwards, in_ready=1 cycle after release.
